imem_fetch_ctrl: RTL and testbench

Fetch sequencer between the fetch stage (PC register, Fetch/Decode register) and a variable-latency instruction memory with a req/ack handshake. Issues one fetch per PC, converts memory wait cycles into fetch stalls and Decode bubbles, and merges them with hazard-unit stall/flush requests. Discards wrong-path returns after a taken branch/jump resolved in Execute. Counts memory-induced fetch stall cycles for performance monitoring.

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer between the PC / Fetch-Decode registers and a variable-latency
// instruction memory with a req/ack handshake. Turns memory wait cycles into fetch
// stalls and Decode bubbles, merges them with hazard-unit requests, discards
// wrong-path returns after an Execute redirect and counts memory stall cycles.
module imem_fetch_ctrl #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PCF,
    input  logic             PCSrcE,
    input  logic             HazStallF,
    input  logic             HazStallD,
    input  logic             HazFlushD,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] InstrF,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] ibuf_q, ibuf_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             cnt_inc;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // State, outstanding address, buffered instruction and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ibuf_q      <= NOP;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ibuf_q      <= ibuf_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Mealy next-state and output decode; defaults are the "no valid fetch" values
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ibuf_d    = ibuf_q;
        cnt_inc   = 1'b0;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        InstrF    = NOP;
        StallF    = 1'b1;
        StallD    = 1'b0;
        FlushD    = 1'b1;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = PCF;
                addr_d    = PCF;
                if (imem_ack) begin
                    if (PCSrcE) begin
                        // Wrong-path data: let the PC take the target, bubble Decode
                        StallF = 1'b0;
                    end else begin
                        InstrF = imem_rdata;
                        StallF = HazStallF;
                        StallD = HazStallD;
                        FlushD = HazFlushD;
                        if (HazStallF) begin
                            ibuf_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end else begin
                    cnt_inc = 1'b1;
                    if (PCSrcE) begin
                        // Request stays on the bus (PCF moves), so remember to drop it
                        StallF  = 1'b0;
                        state_d = DROP;
                    end else if (HazStallD) begin
                        StallD = 1'b1;
                        FlushD = HazFlushD;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    StallF  = 1'b0;
                    state_d = REQ;
                end else begin
                    InstrF = ibuf_q;
                    StallF = HazStallF;
                    StallD = HazStallD;
                    FlushD = HazFlushD;
                    if (!HazStallF) begin
                        state_d = REQ;
                    end
                end
            end
            DROP: begin
                // Keep the abandoned request stable until memory completes it
                imem_req = 1'b1;
                cnt_inc  = 1'b1;
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_cnt_d = cnt_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: closed-loop PC register and variable-latency memory
// models driven by a reference model; expected outputs are queued per cycle and a
// negedge monitor compares them against the DUT.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        PCSrcE, HazStallF, HazStallD, HazFlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic        StallF, StallD, FlushD;
    logic [31:0] stall_cnt;

    imem_fetch_ctrl #(.WIDTH(32), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PCSrcE(PCSrcE),
        .HazStallF(HazStallF), .HazStallD(HazStallD), .HazFlushD(HazFlushD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .InstrF(InstrF), .StallF(StallF),
        .StallD(StallD), .FlushD(FlushD), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        sf, sd, fd;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase flags of the fetch sequence
    bit          m_boot, m_hold, m_drop;
    logic [31:0] m_saved, m_buf;
    longint      m_cnt;
    logic [31:0] pc;
    // Memory model
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_data;
    int          lat_mode;
    bit          force_valid;
    logic [31:0] force_data;
    // Values applied in the previous cycle
    bit          p_rst, p_req, p_ack, p_pcs, p_hsf, p_sf;
    logic [31:0] p_tgt, p_pcf, p_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare every queued expectation away from the active edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            chk("imem_req", {31'd0, imem_req}, {31'd0, mon_e.req});
            if (mon_e.req) chk("imem_addr", imem_addr, mon_e.addr);
            chk("InstrF", InstrF, mon_e.instr);
            chk("StallF", {31'd0, StallF}, {31'd0, mon_e.sf});
            chk("StallD", {31'd0, StallD}, {31'd0, mon_e.sd});
            chk("FlushD", {31'd0, FlushD}, {31'd0, mon_e.fd});
            chk("stall_cnt", stall_cnt, mon_e.cnt);
        end
    end

    task automatic model_reset();
        m_boot   = 1'b1;
        m_hold   = 1'b0;
        m_drop   = 1'b0;
        m_saved  = '0;
        m_buf    = NOP;
        m_cnt    = 0;
        mem_busy = 1'b0;
        pc       = '0;
    endtask

    task automatic count_stall();
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    endtask

    // One clock cycle: advance models across the edge, then apply and predict
    task automatic step(input bit rst_v, input bit pcs, input logic [31:0] tgt,
                        input bit hsf, input bit hsd, input bit hfd);
        exp_t e;
        logic [31:0] rd;
        @(posedge clk);
        if (p_rst) begin
            if (!p_sf) pc = p_pcs ? p_tgt : pc + 32'd4;
            if (p_req) begin
                if (p_ack) mem_busy = 1'b0;
                else mem_wait--;
            end
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_drop) begin
                count_stall();
                if (p_ack) m_drop = 1'b0;
            end else if (m_hold) begin
                if (p_pcs || !p_hsf) m_hold = 1'b0;
            end else begin
                m_saved = p_pcf;
                if (!p_ack) begin
                    count_stall();
                    if (p_pcs) m_drop = 1'b1;
                end else if (!p_pcs && p_hsf) begin
                    m_buf  = p_rdata;
                    m_hold = 1'b1;
                end
            end
        end
        #1;
        if (!rst_v) model_reset();

        e.req = 1'b0; e.addr = '0; e.instr = NOP;
        e.sf = 1'b1; e.sd = 1'b0; e.fd = 1'b1;
        if (rst_v && !m_boot && !m_hold) begin
            e.req  = 1'b1;
            e.addr = m_drop ? m_saved : pc;
        end
        if (e.req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            mem_data = force_valid ? force_data : $urandom;
            force_valid = 1'b0;
        end
        imem_ack = e.req && mem_busy && (mem_wait == 0);
        rd = imem_ack ? mem_data : $urandom;

        reset = rst_v; PCF = pc; PCSrcE = pcs; imem_rdata = rd;
        HazStallF = hsf; HazStallD = hsd; HazFlushD = hfd;

        if (rst_v && !m_boot && !m_drop) begin
            if (m_hold) begin
                if (pcs) begin
                    e.sf = 1'b0;
                end else begin
                    e.instr = m_buf; e.sf = hsf; e.sd = hsd; e.fd = hfd;
                end
            end else if (imem_ack) begin
                if (pcs) begin
                    e.sf = 1'b0;
                end else begin
                    e.instr = rd; e.sf = hsf; e.sd = hsd; e.fd = hfd;
                end
            end else if (pcs) begin
                e.sf = 1'b0;
            end else if (hsd) begin
                e.sd = 1'b1; e.fd = hfd;
            end
        end
        e.cnt = m_cnt[31:0];
        sb.push_back(e);

        p_rst = rst_v; p_req = e.req; p_ack = imem_ack; p_pcs = pcs;
        p_hsf = hsf; p_sf = e.sf; p_tgt = tgt; p_pcf = pc; p_rdata = rd;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; PCF = '0; PCSrcE = 1'b0; HazStallF = 1'b0;
        HazStallD = 1'b0; HazFlushD = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        p_rst = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_pcs = 1'b0; p_hsf = 1'b0;
        p_sf = 1'b1; p_tgt = '0; p_pcf = '0; p_rdata = '0;
        force_valid = 1'b0; force_data = '0; mem_wait = 0; mem_data = '0;
        model_reset();

        // Reset, then zero-wait fetches from PC 0
        lat_mode = 0;
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        quiet(5);
        // 3-wait fetch at PC 0x10
        lat_mode = 3;
        quiet(4);
        // Redirect together with ack
        lat_mode = 0;
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        // Redirect on the first wait cycle of a 4-wait fetch at 0x20
        lat_mode = 4;
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        quiet(4);
        // Hazard hold on the 0x100 fetch
        lat_mode = 0;
        force_valid = 1'b1; force_data = 32'hDEADBEEF;
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        quiet(2);
        // Redirect during a wait, then async reset in the middle of DROP
        lat_mode = 4;
        step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        quiet(1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        quiet(3);

        // Randomized traffic
        lat_mode = -1;
        for (int i = 0; i < 1500; i++) begin
            bit r, pcs, hsf, hsd, hfd;
            r   = ($urandom_range(0, 299) != 0);
            pcs = ($urandom_range(0, 5) == 0);
            hsf = ($urandom_range(0, 3) == 0);
            hsd = hsf | ($urandom_range(0, 7) == 0);
            hfd = ($urandom_range(0, 7) == 0);
            step(r, pcs, $urandom & 32'h0000_FFFC, hsf, hsd, hfd);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
